// File: rtl/jlu_pkg.sv
// Shared jump/link definitions: jump-kind encoding,
// link-register constants and the is_link() helper.
package jlu_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    JAL  = 2'd1,
    JALR = 2'd2,
    BR   = 2'd3
  } kind_e;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  function automatic logic is_link(input logic [4:0] idx);
    return (idx == LINK_X1) || (idx == LINK_X5);
  endfunction

endpackage

// File: rtl/jump_link_unit_ras.sv
// ras_stack: circular return-address stack.
// push/pop (both = replace top), data -> top, count, sticky ovf/unf.
module ras_stack #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [XLEN-1:0]          data,
  output logic [XLEN-1:0]          top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   sp;
  logic [PW-1:0]   sp_m1;
  logic [PW-1:0]   wr_idx;
  logic            empty;
  logic            full;
  logic            hit;

  assign sp_m1 = sp - PW'(1);
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign hit   = pop && !empty;
  assign top   = mem[sp_m1];

  // A pop+push replaces the current top in place.
  assign wr_idx = hit ? sp_m1 : sp;

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= data;
  end

  // When full, sp already points at the oldest entry,
  // so a push overwrites it and count saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (pop && empty) unf <= 1'b1;
      if (hit && !push) begin
        sp    <= sp_m1;
        count <= count - CW'(1);
      end else if (push && !hit) begin
        sp <= sp + PW'(1);
        if (full) ovf <= 1'b1;
        else      count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/jump_link_unit.sv
// Jump/link resolution: next PC, link write, RAS return prediction.
// Registered outputs. RAS present only when JLU_RAS_EN is defined.
module jump_link_unit
  import jlu_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              RAS_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = 'h8000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_i,
  input  logic [1:0]                 kind_i,
  input  logic                       taken_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [XLEN-1:0]            imm_i,
  input  logic [XLEN-1:0]            rs1_val_i,
  input  logic [4:0]                 rs1_idx_i,
  input  logic [4:0]                 rd_idx_i,
  output logic [XLEN-1:0]            next_pc_o,
  output logic                       redirect_o,
  output logic                       link_we_o,
  output logic [4:0]                 link_addr_o,
  output logic [XLEN-1:0]            link_data_o,
  output logic                       misalign_o,
  output logic                       ras_pred_valid_o,
  output logic                       ras_mispredict_o,
  output logic [$clog2(RAS_DEPTH):0] ras_count_o,
  output logic                       ras_ovf_o,
  output logic                       ras_unf_o
);

  kind_e           kind;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_tgt;
  logic [XLEN-1:0] target;
  logic            jump;
  logic            redir;

  assign kind    = kind_e'(kind_i);
  assign seq_pc  = pc_i + XLEN'(4);
  assign rel_tgt = pc_i + imm_i;
  assign redir   = (target != seq_pc);

  always_comb begin
    target = seq_pc;
    jump   = 1'b0;
    unique case (kind)
      JAL: begin
        target = rel_tgt;
        jump   = 1'b1;
      end
      JALR: begin
        target = (rs1_val_i + imm_i) & ~XLEN'(1);
        jump   = 1'b1;
      end
      BR: begin
        if (taken_i) target = rel_tgt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_pc_o   <= RESET_PC;
      redirect_o  <= 1'b0;
      link_we_o   <= 1'b0;
      link_addr_o <= '0;
      link_data_o <= '0;
      misalign_o  <= 1'b0;
    end else if (valid_i) begin
      next_pc_o   <= target;
      redirect_o  <= redir;
      link_we_o   <= jump && (rd_idx_i != '0);
      link_addr_o <= rd_idx_i;
      link_data_o <= seq_pc;
      misalign_o  <= redir && (target[1:0] != 2'b00);
    end else begin
      redirect_o  <= 1'b0;
      link_we_o   <= 1'b0;
      misalign_o  <= 1'b0;
    end
  end

`ifdef JLU_RAS_EN
  logic            rd_link;
  logic            rs1_link;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_hit;
  logic [XLEN-1:0] ras_top;
  logic            pred_q;
  logic            miss_q;

  assign rd_link  = is_link(rd_idx_i);
  assign rs1_link = is_link(rs1_idx_i);
  assign ras_push = valid_i && jump && rd_link;
  // rd == rs1 == link is a plain push, not a return.
  assign ras_pop  = valid_i && (kind == JALR) && rs1_link
                 && !(rd_link && (rd_idx_i == rs1_idx_i));
  assign ras_hit  = ras_pop && (ras_count_o != '0);

  ras_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .data  (seq_pc),
    .top   (ras_top),
    .count (ras_count_o),
    .ovf   (ras_ovf_o),
    .unf   (ras_unf_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_q <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      pred_q <= ras_hit;
      miss_q <= ras_hit && (ras_top != target);
    end
  end

  assign ras_pred_valid_o = pred_q;
  assign ras_mispredict_o = miss_q;
`else
  logic unused_rs1;
  assign unused_rs1       = ^rs1_idx_i;
  assign ras_pred_valid_o = 1'b0;
  assign ras_mispredict_o = 1'b0;
  assign ras_count_o      = '0;
  assign ras_ovf_o        = 1'b0;
  assign ras_unf_o        = 1'b0;
`endif

endmodule

// File: tb/tb_jump_link_unit.sv
// Self-checking bench for jump_link_unit: directed table,
// async reset sequence, random stimulus vs a queue-based model.
module tb_jump_link_unit;
  import jlu_pkg::*;

`ifdef JLU_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, taken_i;
  logic [1:0]  kind_i;
  logic [31:0] pc_i, imm_i, rs1_val_i;
  logic [4:0]  rs1_idx_i, rd_idx_i;
  logic [31:0] next_pc_o, link_data_o;
  logic        redirect_o, link_we_o, misalign_o;
  logic [4:0]  link_addr_o;
  logic        ras_pred_valid_o, ras_mispredict_o;
  logic [2:0]  ras_count_o;
  logic        ras_ovf_o, ras_unf_o;

  always #5 clk = ~clk;

  jump_link_unit #(
    .XLEN      (32),
    .RAS_DEPTH (DEPTH),
    .RESET_PC  (32'h8000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_i          (valid_i),
    .kind_i           (kind_i),
    .taken_i          (taken_i),
    .pc_i             (pc_i),
    .imm_i            (imm_i),
    .rs1_val_i        (rs1_val_i),
    .rs1_idx_i        (rs1_idx_i),
    .rd_idx_i         (rd_idx_i),
    .next_pc_o        (next_pc_o),
    .redirect_o       (redirect_o),
    .link_we_o        (link_we_o),
    .link_addr_o      (link_addr_o),
    .link_data_o      (link_data_o),
    .misalign_o       (misalign_o),
    .ras_pred_valid_o (ras_pred_valid_o),
    .ras_mispredict_o (ras_mispredict_o),
    .ras_count_o      (ras_count_o),
    .ras_ovf_o        (ras_ovf_o),
    .ras_unf_o        (ras_unf_o)
  );

  typedef struct {
    logic        v;
    logic [1:0]  k;
    logic        tk;
    logic [31:0] pc, imm, rv;
    logic [4:0]  rs1, rd;
  } in_t;

  typedef struct {
    logic [31:0] npc;
    logic        redir, we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        mis, pv, mp;
    logic [2:0]  cnt;
    logic        ovf, unf;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t tab[$];
  int   tests = 0;
  int   fails = 0;

  // reference model state
  logic [31:0] m_npc;
  logic [31:0] m_q[$];
  logic        m_ovf, m_unf;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic check_out(input string t, input out_t e);
    out_t x;
    x = e;
    if (!RAS_EN) begin
      x.pv = 0; x.mp = 0; x.cnt = 0; x.ovf = 0; x.unf = 0;
    end
    chk({t, ".next_pc"}, next_pc_o, x.npc);
    chk({t, ".redirect"}, 32'(redirect_o), 32'(x.redir));
    chk({t, ".link_we"}, 32'(link_we_o), 32'(x.we));
    if (x.we) begin
      chk({t, ".link_addr"}, 32'(link_addr_o), 32'(x.addr));
      chk({t, ".link_data"}, link_data_o, x.data);
    end
    chk({t, ".misalign"}, 32'(misalign_o), 32'(x.mis));
    chk({t, ".pred"}, 32'(ras_pred_valid_o), 32'(x.pv));
    chk({t, ".mispred"}, 32'(ras_mispredict_o), 32'(x.mp));
    chk({t, ".count"}, 32'(ras_count_o), 32'(x.cnt));
    chk({t, ".ovf"}, 32'(ras_ovf_o), 32'(x.ovf));
    chk({t, ".unf"}, 32'(ras_unf_o), 32'(x.unf));
  endtask

  task automatic drive(input in_t i);
    valid_i   = i.v;
    kind_i    = i.k;
    taken_i   = i.tk;
    pc_i      = i.pc;
    imm_i     = i.imm;
    rs1_val_i = i.rv;
    rs1_idx_i = i.rs1;
    rd_idx_i  = i.rd;
  endtask

  task automatic apply(input in_t i);
    drive(i);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_t i;
    i = '{v:0, k:0, tk:0, pc:0, imm:0, rv:0, rs1:0, rd:0};
    drive(i);
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_npc = 32'h8000;
    m_q.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  function automatic in_t mk(logic v, logic [1:0] k, logic tk,
      logic [31:0] pc, logic [31:0] imm, logic [31:0] rv,
      logic [4:0] rs1, logic [4:0] rd);
    in_t i;
    i = '{v:v, k:k, tk:tk, pc:pc, imm:imm, rv:rv, rs1:rs1, rd:rd};
    return i;
  endfunction

  function automatic void add(in_t i, logic [31:0] npc,
      logic redir, logic we, logic [4:0] addr, logic [31:0] data,
      logic mis, logic pv, logic mp, logic [2:0] cnt,
      logic ovf, logic unf);
    vec_t t;
    t.i = i;
    t.o = '{npc:npc, redir:redir, we:we, addr:addr, data:data,
            mis:mis, pv:pv, mp:mp, cnt:cnt, ovf:ovf, unf:unf};
    tab.push_back(t);
  endfunction

  // Spec-level model: RAS is a bounded queue, newest at the back.
  task automatic model(input in_t i, output out_t e);
    logic [31:0] t, seq;
    logic        pop, push;
    e = '{npc:m_npc, redir:0, we:0, addr:0, data:0, mis:0,
          pv:0, mp:0, cnt:0, ovf:0, unf:0};
    if (i.v) begin
      seq = i.pc + 4;
      case (i.k)
        2'd1: t = i.pc + i.imm;
        2'd2: t = (i.rv + i.imm) & 32'hFFFF_FFFE;
        2'd3: t = i.tk ? i.pc + i.imm : seq;
        default: t = seq;
      endcase
      m_npc   = t;
      e.npc   = t;
      e.redir = (t != seq);
      e.mis   = e.redir && (t % 4 != 0);
      e.we    = (i.k == 1 || i.k == 2) && i.rd != 0;
      e.addr  = i.rd;
      e.data  = seq;
      push = (i.k == 1 || i.k == 2) && is_link(i.rd);
      pop  = i.k == 2 && is_link(i.rs1)
          && !(is_link(i.rd) && i.rd == i.rs1);
      if (pop) begin
        if (m_q.size() > 0) begin
          e.pv = 1;
          e.mp = (m_q[$] != t);
          void'(m_q.pop_back());
        end else begin
          m_unf = 1;
        end
      end
      if (push) begin
        m_q.push_back(seq);
        if (m_q.size() > DEPTH) begin
          void'(m_q.pop_front());
          m_ovf = 1;
        end
      end
    end
    e.cnt = 3'(m_q.size());
    e.ovf = m_ovf;
    e.unf = m_unf;
  endtask

  initial begin
    out_t e;
    in_t  i;
    logic [4:0] regs [4];
    regs = '{5'd0, 5'd1, 5'd5, 5'd3};
    rst = 1'b1;
    idle();
    #3;
    e = '{npc:32'h8000, redir:0, we:0, addr:0, data:0, mis:0,
          pv:0, mp:0, cnt:0, ovf:0, unf:0};
    check_out("reset", e);
    chk("reset.link_addr", 32'(link_addr_o), 32'd0);
    chk("reset.link_data", link_data_o, 32'd0);

    // directed table
    add(mk(1,1,0,32'h8000,32'h8,0,0,3),
        32'h8008,1,1,3,32'h8004,0,0,0,0,0,0);
    add(mk(1,1,0,32'h8000,32'h100,0,0,1),
        32'h8100,1,1,1,32'h8004,0,0,0,1,0,0);
    add(mk(1,2,0,32'h8100,0,32'h8004,1,0),
        32'h8004,1,0,0,0,0,1,0,0,0,0);
    add(mk(1,1,0,32'h8000,32'h100,0,0,1),
        32'h8100,1,1,1,32'h8004,0,0,0,1,0,0);
    add(mk(1,2,0,32'h8100,0,32'h9000,1,0),
        32'h9000,1,0,0,0,0,1,1,0,0,0);
    for (int j = 1; j <= 5; j++)
      add(mk(1,1,0,32'(j) << 12,32'h10,0,0,1),
          (32'(j) << 12) + 32'h10,1,1,1,(32'(j) << 12) + 4,
          0,0,0,3'((j > 4) ? 4 : j),j == 5,0);
    for (int j = 5; j >= 2; j--)
      add(mk(1,2,0,32'h6000,0,(32'(j) << 12) + 4,1,0),
          (32'(j) << 12) + 4,1,0,0,0,0,1,0,3'(j - 2),1,0);
    add(mk(1,2,0,32'h6000,0,32'h1004,1,0),
        32'h1004,1,0,0,0,0,0,0,0,1,1);
    add(mk(1,2,0,32'h7000,0,32'h8001,2,0),
        32'h8000,1,0,0,0,0,0,0,0,1,1);
    add(mk(1,2,0,32'h7000,0,32'h8002,2,0),
        32'h8002,1,0,0,0,1,0,0,0,1,1);
    add(mk(1,2,0,32'h7000,0,32'h8002,2,3),
        32'h8002,1,1,3,32'h7004,1,0,0,0,1,1);
    add(mk(1,3,0,32'h7000,32'hFFFF_FFF8,0,0,0),
        32'h7004,0,0,0,0,0,0,0,0,1,1);
    add(mk(1,3,1,32'h7000,32'hFFFF_FFF8,0,0,0),
        32'h6FF8,1,0,0,0,0,0,0,0,1,1);
    add(mk(1,3,1,32'h7000,32'h2,0,0,0),
        32'h7002,1,0,0,0,1,0,0,0,1,1);
    add(mk(0,1,0,32'h1000,32'h40,0,0,1),
        32'h7002,0,0,0,0,0,0,0,0,1,1);
    add(mk(1,0,0,32'h7FFC,0,0,0,0),
        32'h8000,0,0,0,0,0,0,0,0,1,1);
    add(mk(1,1,0,32'h100,32'h40,0,0,1),
        32'h140,1,1,1,32'h104,0,0,0,1,1,1);
    add(mk(1,2,0,32'h140,0,32'h104,5,1),
        32'h104,1,1,1,32'h144,0,1,0,1,1,1);
    add(mk(1,2,0,32'h200,0,32'h144,1,0),
        32'h144,1,0,0,0,0,1,0,0,1,1);
    add(mk(1,2,0,32'h400,32'h4,32'h300,1,1),
        32'h304,1,1,1,32'h404,0,0,0,1,1,1);

    do_reset();
    for (int n = 0; n < tab.size(); n++) begin
      apply(tab[n].i);
      check_out($sformatf("vec%0d", n), tab[n].o);
    end

    // asynchronous reset between call and return
    do_reset();
    apply(mk(1,1,0,32'h8000,32'h100,0,0,1));
    chk("arst.pre_count", 32'(ras_count_o), RAS_EN ? 32'd1 : 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.next_pc", next_pc_o, 32'h8000);
    chk("arst.count", 32'(ras_count_o), 32'd0);
    chk("arst.link_we", 32'(link_we_o), 32'd0);
    rst = 1'b0;
    apply(mk(1,2,0,32'h8100,0,32'h8004,1,0));
    e = '{npc:32'h8004, redir:1, we:0, addr:0, data:0, mis:0,
          pv:0, mp:0, cnt:0, ovf:0, unf:1};
    check_out("arst.ret", e);

    // random stimulus against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      i.v   = ($urandom_range(0, 9) != 0);
      i.k   = 2'($urandom_range(0, 3));
      i.tk  = 1'($urandom_range(0, 1));
      i.pc  = {$urandom_range(0, 32'hFFFF), 2'b00} << 2;
      i.imm = ($urandom_range(0, 3) == 0) ? $urandom
            : 32'($signed($urandom_range(0, 255)) - 128);
      i.rs1 = regs[$urandom_range(0, 3)];
      i.rd  = regs[$urandom_range(0, 3)];
      i.rv  = $urandom;
      if (m_q.size() > 0 && $urandom_range(0, 1) == 1)
        i.rv = m_q[$] - i.imm;
      model(i, e);
      apply(i);
      check_out($sformatf("rnd%0d", n), e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
